// File: rtl/dcp_pkg.sv
// Shared definitions for the debug-port host.
//   Opcodes     : CMD_WI .. CMD_STAT, the first byte of every command
//   Reply bytes : ACK_BYTE (write/run/halt done), ERR_BYTE (rejected/unknown)
//   FSM states  : S_IDLE .. S_SEND
package dcp_pkg;

   localparam logic [7:0] CMD_WI   = 8'h01;
   localparam logic [7:0] CMD_WD   = 8'h02;
   localparam logic [7:0] CMD_RD   = 8'h03;
   localparam logic [7:0] CMD_RR   = 8'h04;
   localparam logic [7:0] CMD_RUN  = 8'h05;
   localparam logic [7:0] CMD_HALT = 8'h06;
   localparam logic [7:0] CMD_STAT = 8'h07;

   localparam logic [7:0] ACK_BYTE = 8'hAA;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_GET_ADDR = 3'd1;
   localparam logic [2:0] S_GET_DATA = 3'd2;
   localparam logic [2:0] S_EXEC     = 3'd3;
   localparam logic [2:0] S_RD_WAIT  = 3'd4;
   localparam logic [2:0] S_SEND     = 3'd5;

   // Opcodes followed by an address byte.
   function automatic logic has_addr(input logic [7:0] op);
      return (op == CMD_WI) || (op == CMD_WD) || (op == CMD_RD) || (op == CMD_RR);
   endfunction

   // Opcodes executed with no operand bytes.
   function automatic logic is_bare(input logic [7:0] op);
      return (op == CMD_RUN) || (op == CMD_HALT) || (op == CMD_STAT);
   endfunction

endpackage

// File: rtl/dcp_shift32.sv
// 32-bit byte shift register used both to gather operand words and to
// serialise reply words, MSB byte first.
//   i_clk, i_rst      : clock, async active-high reset
//   i_clr             : clear byte counter only
//   i_load/i_load_word: parallel load (also clears counter)
//   i_push/i_byte     : shift a byte in at the LSB end, count++
//   i_pop             : shift out the MSB byte, count++
//   o_word, o_byte    : full word, current MSB byte
//   o_cnt             : bytes pushed/popped since last clear/load (wraps)
module dcp_shift32 (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_load,
   input  logic [31:0] i_load_word,
   input  logic        i_push,
   input  logic [7:0]  i_byte,
   input  logic        i_pop,
   output logic [31:0] o_word,
   output logic [7:0]  o_byte,
   output logic [1:0]  o_cnt
);

   logic [31:0] r_word;
   logic [1:0]  r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_word <= i_load_word;
         r_cnt  <= '0;
      end else if (i_push) begin
         r_word <= {r_word[23:0], i_byte};
         r_cnt  <= r_cnt + 2'd1;
      end else if (i_pop) begin
         r_word <= {r_word[23:0], 8'h00};
         r_cnt  <= r_cnt + 2'd1;
      end else if (i_clr) begin
         r_cnt  <= '0;
      end
   end

   assign o_word = r_word;
   assign o_byte = r_word[31:24];
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/dcp_host.sv
// Debug-port host: decodes a byte-stream command protocol and drives the
// CPU debug interface, returning replies as a byte stream. Owns CPU reset.
//   i_clk, i_rst                      : clock, async active-high reset
//   i_rx_data/i_rx_valid/o_rx_ready   : command byte stream in
//   o_tx_data/o_tx_valid/i_tx_ready   : reply byte stream out
//   o_cpu_rstn, i_cpu_stop            : CPU reset (active-low), CPU stop status
//   o_inst_we/o_inst_addr/o_inst_in   : instruction-memory write
//   o_data_we/o_data_addr/o_data_in   : data-memory write; data_addr also reads
//   i_data_out                        : data-memory read value
//   o_rf_dcp_rd/o_rf_addr, i_rf_out   : register-file read
module dcp_host
   import dcp_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [7:0]           i_rx_data,
   input  logic                 i_rx_valid,
   output logic                 o_rx_ready,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic                 o_cpu_rstn,
   input  logic                 i_cpu_stop,
   output logic                 o_inst_we,
   output logic [ADDR_W-1:0]    o_inst_addr,
   output logic [DATA_W-1:0]    o_inst_in,
   output logic                 o_data_we,
   output logic [ADDR_W-1:0]    o_data_addr,
   output logic [DATA_W-1:0]    o_data_in,
   input  logic [DATA_W-1:0]    i_data_out,
   output logic                 o_rf_dcp_rd,
   output logic [RF_ADDR_W-1:0] o_rf_addr,
   input  logic [DATA_W-1:0]    i_rf_out
);

   logic [2:0]  r_state, w_state_d;
   logic [7:0]  r_op, w_op_d;
   logic [7:0]  r_addr, w_addr_d;
   logic        r_cpu_rstn, w_cpu_rstn_d;
   logic        r_four, w_four_d;   // reply is a 4-byte word, else 1 byte
   logic        r_rdy_en;           // holds rx_ready low for the first cycle after reset

   logic        w_clr, w_load, w_push, w_pop;
   logic [31:0] w_load_word, w_word;
   logic [7:0]  w_byte;
   logic [1:0]  w_cnt;
   logic        w_rx_fire, w_tx_fire;

   dcp_shift32 u_shift (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_clr),
      .i_load      (w_load),
      .i_load_word (w_load_word),
      .i_push      (w_push),
      .i_byte      (i_rx_data),
      .i_pop       (w_pop),
      .o_word      (w_word),
      .o_byte      (w_byte),
      .o_cnt       (w_cnt)
   );

   assign o_rx_ready = r_rdy_en &&
                       (r_state == S_IDLE || r_state == S_GET_ADDR || r_state == S_GET_DATA);
   assign o_tx_valid = (r_state == S_SEND);
   assign o_tx_data  = w_byte;
   assign w_rx_fire  = i_rx_valid && o_rx_ready;
   assign w_tx_fire  = o_tx_valid && i_tx_ready;

   always_comb begin
      w_state_d    = r_state;
      w_op_d       = r_op;
      w_addr_d     = r_addr;
      w_cpu_rstn_d = r_cpu_rstn;
      w_four_d     = r_four;
      w_clr        = 1'b0;
      w_load       = 1'b0;
      w_load_word  = '0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clr = 1'b1;
            if (w_rx_fire) begin
               w_op_d = i_rx_data;
               if (has_addr(i_rx_data)) begin
                  w_state_d = S_GET_ADDR;
               end else if (is_bare(i_rx_data)) begin
                  w_state_d = S_EXEC;
               end else begin
                  // Unknown opcode: reject without consuming any operand bytes.
                  w_load      = 1'b1;
                  w_load_word = {ERR_BYTE, 24'h0};
                  w_four_d    = 1'b0;
                  w_state_d   = S_SEND;
               end
            end
         end
         S_GET_ADDR: begin
            if (w_rx_fire) begin
               w_addr_d  = i_rx_data;
               w_state_d = (r_op == CMD_WI || r_op == CMD_WD) ? S_GET_DATA : S_EXEC;
            end
         end
         S_GET_DATA: begin
            if (w_rx_fire) begin
               w_push = 1'b1;
               if (w_cnt == 2'd3) w_state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            w_four_d    = 1'b0;
            w_load      = 1'b1;
            w_load_word = {ACK_BYTE, 24'h0};
            w_state_d   = S_SEND;
            case (r_op)
               CMD_WI, CMD_WD: if (r_cpu_rstn) w_load_word = {ERR_BYTE, 24'h0};
               CMD_RD: begin
                  w_load    = 1'b0;
                  w_state_d = S_RD_WAIT;
               end
               CMD_RR: begin
                  if (r_cpu_rstn) begin
                     w_load_word = {ERR_BYTE, 24'h0};
                  end else begin
                     w_load    = 1'b0;
                     w_state_d = S_RD_WAIT;
                  end
               end
               CMD_RUN:  w_cpu_rstn_d = 1'b1;
               CMD_HALT: w_cpu_rstn_d = 1'b0;
               CMD_STAT: w_load_word = {6'b0, i_cpu_stop, r_cpu_rstn, 24'h0};
               default:  w_load_word = {ERR_BYTE, 24'h0};
            endcase
         end
         S_RD_WAIT: begin
            w_load      = 1'b1;
            w_load_word = (r_op == CMD_RR) ? i_rf_out[31:0] : i_data_out[31:0];
            w_four_d    = 1'b1;
            w_state_d   = S_SEND;
         end
         S_SEND: begin
            if (w_tx_fire) begin
               w_pop = 1'b1;
               if (!r_four || w_cnt == 2'd3) w_state_d = S_IDLE;
            end
         end
         default: w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_addr     <= '0;
         r_cpu_rstn <= 1'b0;
         r_four     <= 1'b0;
         r_rdy_en   <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_op       <= w_op_d;
         r_addr     <= w_addr_d;
         r_cpu_rstn <= w_cpu_rstn_d;
         r_four     <= w_four_d;
         r_rdy_en   <= 1'b1;
      end
   end

   // Strobes decode straight from state so they drop as soon as reset hits.
   assign o_inst_we   = (r_state == S_EXEC) && !r_cpu_rstn && (r_op == CMD_WI);
   assign o_data_we   = (r_state == S_EXEC) && !r_cpu_rstn && (r_op == CMD_WD);
   assign o_rf_dcp_rd = (r_state == S_EXEC || r_state == S_RD_WAIT) && !r_cpu_rstn &&
                        (r_op == CMD_RR);

   assign o_cpu_rstn  = r_cpu_rstn;
   assign o_inst_addr = ADDR_W'(r_addr);
   assign o_data_addr = ADDR_W'(r_addr);
   assign o_rf_addr   = r_addr[RF_ADDR_W-1:0];
   assign o_inst_in   = DATA_W'(w_word);
   assign o_data_in   = DATA_W'(w_word);

endmodule

// File: tb/tb_dcp_host.sv
// Directed bench for dcp_host with a simple memory and register-file model.
module tb_dcp_host;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        cpu_rstn;
   logic        cpu_stop = 1'b0;
   logic        inst_we, data_we, rf_dcp_rd;
   logic [7:0]  inst_addr, data_addr;
   logic [31:0] inst_in, data_in, data_out, rf_out;
   logic [4:0]  rf_addr;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [256];
   logic [31:0] r_dout = '0;
   int          inst_we_cnt = 0, data_we_cnt = 0, rf_rd_cnt = 0, excl_cnt = 0;
   logic [7:0]  cap_inst_addr = '0, cap_data_addr = '0;
   logic [31:0] cap_inst_in = '0, cap_data_in = '0;

   always #5 clk = ~clk;

   dcp_host u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_rx_ready  (rx_ready),
      .o_tx_data   (tx_data),
      .o_tx_valid  (tx_valid),
      .i_tx_ready  (tx_ready),
      .o_cpu_rstn  (cpu_rstn),
      .i_cpu_stop  (cpu_stop),
      .o_inst_we   (inst_we),
      .o_inst_addr (inst_addr),
      .o_inst_in   (inst_in),
      .o_data_we   (data_we),
      .o_data_addr (data_addr),
      .o_data_in   (data_in),
      .i_data_out  (data_out),
      .o_rf_dcp_rd (rf_dcp_rd),
      .o_rf_addr   (rf_addr),
      .i_rf_out    (rf_out)
   );

   // Data memory: read value appears one cycle after the address.
   always @(posedge clk) begin
      if (data_we) mem[data_addr] <= data_in;
      r_dout <= mem[data_addr];
   end
   assign data_out = r_dout;
   assign rf_out   = (rf_addr == 5'd1) ? 32'h0000_0100 : 32'hBAD0_0000;

   always @(negedge clk) begin
      if (inst_we) begin
         inst_we_cnt++;
         cap_inst_addr = inst_addr;
         cap_inst_in   = inst_in;
      end
      if (data_we) begin
         data_we_cnt++;
         cap_data_addr = data_addr;
         cap_data_in   = data_in;
      end
      if (rf_dcp_rd) rf_rd_cnt++;
      if (int'(inst_we) + int'(data_we) + int'(rf_dcp_rd) > 1) excl_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) chk("rx_accept_timeout", 32'(rx_ready), 32'd1);
      else begin
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx();
      int n = 0;
      @(negedge clk);
      while (!tx_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic recv_byte(input logic [7:0] exp, input string tag);
      wait_tx();
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      if (tx_valid) begin
         chk(tag, 32'(tx_data), 32'(exp));
         tx_ready = 1'b1;
         @(posedge clk);
         #1;
         tx_ready = 1'b0;
      end
   endtask

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_strobes", {29'd0, inst_we, data_we, rf_dcp_rd}, 32'd0);
      chk("rst_inst_addr", 32'(inst_addr), 32'd0);
      chk("rst_data_in", data_in, 32'd0);
      rst = 1'b0;
      chk("rst_rx_ready_first", 32'(rx_ready), 32'd0);
      @(negedge clk);
      chk("rx_ready_after", 32'(rx_ready), 32'd1);

      // WI while halted.
      send_byte(8'h01); send_byte(8'h05);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      recv_byte(8'hAA, "wi_ack");
      chk("wi_we_count", 32'(inst_we_cnt), 32'd1);
      chk("wi_addr", 32'(cap_inst_addr), 32'h05);
      chk("wi_data", cap_inst_in, 32'h1234_5678);

      // WD then RD, with a 10-cycle stall on the first reply byte.
      send_byte(8'h02); send_byte(8'h10);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      recv_byte(8'hAA, "wd_ack");
      chk("wd_we_count", 32'(data_we_cnt), 32'd1);
      chk("wd_addr", 32'(cap_data_addr), 32'h10);
      chk("wd_data", cap_data_in, 32'hDEAD_BEEF);
      send_byte(8'h03); send_byte(8'h10);
      wait_tx();
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(tx_valid), 32'd1);
         chk("stall_data", 32'(tx_data), 32'hDE);
         @(negedge clk);
      end
      recv_byte(8'hDE, "rd_b0");
      recv_byte(8'hAD, "rd_b1");
      recv_byte(8'hBE, "rd_b2");
      recv_byte(8'hEF, "rd_b3");

      // RUN, STAT, RUN again, then rejected WI and RR.
      send_byte(8'h05);
      recv_byte(8'hAA, "run_ack");
      chk("run_rstn", 32'(cpu_rstn), 32'd1);
      send_byte(8'h07);
      recv_byte(8'h01, "stat_running");
      send_byte(8'h05);
      recv_byte(8'hAA, "run2_ack");
      chk("run2_rstn", 32'(cpu_rstn), 32'd1);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h13);
      recv_byte(8'hEE, "wi_running_err");
      chk("wi_running_no_we", 32'(inst_we_cnt), 32'd1);
      send_byte(8'h04); send_byte(8'h01);
      recv_byte(8'hEE, "rr_running_err");
      chk("rr_running_no_rd", 32'(rf_rd_cnt), 32'd0);

      // HALT twice, then RR.
      send_byte(8'h06);
      recv_byte(8'hAA, "halt_ack");
      chk("halt_rstn", 32'(cpu_rstn), 32'd0);
      send_byte(8'h06);
      recv_byte(8'hAA, "halt2_ack");
      chk("halt2_rstn", 32'(cpu_rstn), 32'd0);
      send_byte(8'h04); send_byte(8'h01);
      recv_byte(8'h00, "rr_b0");
      recv_byte(8'h00, "rr_b1");
      recv_byte(8'h01, "rr_b2");
      recv_byte(8'h00, "rr_b3");
      chk("rr_rd_cycles", 32'(rf_rd_cnt), 32'd2);

      // Unknown opcode, next byte is a fresh opcode.
      send_byte(8'h3C);
      recv_byte(8'hEE, "unknown_err");
      cpu_stop = 1'b1;
      send_byte(8'h07);
      recv_byte(8'h02, "stat_stop");
      cpu_stop = 1'b0;

      // Reset in the middle of a WD.
      send_byte(8'h05);
      recv_byte(8'hAA, "run3_ack");
      send_byte(8'h02); send_byte(8'h10); send_byte(8'hDE);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_data_we", 32'(data_we), 32'd0);
      chk("midrst_rstn", 32'(cpu_rstn), 32'd0);
      chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h07);
      recv_byte(8'h00, "stat_after_rst");
      chk("midrst_no_we", 32'(data_we_cnt), 32'd1);
      chk("strobe_exclusive", 32'(excl_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
